// File: rtl/alu_seq.sv
// alu_seq: sequenced ALU that feeds the accumulator register.
//
// Purpose:
//   Runs one operation on two WIDTH-bit operands chosen by a 4-bit opcode.
//   The result, the remainder and the status flags are registered.
//   A one-cycle load strobe tells the accumulator to capture the result.
//   - Simple ops and divide-by-zero finish on the edge that accepts start.
//   - MUL (shift-add) runs WIDTH iterations after the accepting edge.
//   - DIV (restoring) also runs WIDTH iterations after the accepting edge.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; aborts any iterative op
//   start    request, accepted on a rising edge while busy is low
//   op       opcode, sampled with start
//            0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR,
//            8 PASSB, 9 MUL, 10 DIV, 11-15 pass A
//   a, b     operands, sampled with start
//   result   registered result
//   rem      DIV remainder; 0 for every other op
//   done     one-cycle pulse: result, rem and flags are fresh
//   ac_load  same as done; drives the accumulator read-enable
//   busy     high while MUL/DIV iterations are running
//   zero     result == 0
//   carry    carry / borrow / shift-out / MUL overflow
//   neg      result MSB
//   dbz      divide by zero
module alu_seq #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             done,
    output logic             ac_load,
    output logic             busy,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             dbz
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_PASSB = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;

    // Iteration working registers. These are never reset.
    // They are always reloaded when an op is accepted.
    logic [2*WIDTH-1:0] mc;    // shifted multiplicand
    logic [2*WIDTH-1:0] acc;   // partial product
    logic [WIDTH-1:0]   mb;    // remaining multiplier bits
    logic [WIDTH-1:0]   quo;   // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   prem;  // partial remainder
    logic [WIDTH-1:0]   dvs;   // divisor

    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   prem_nxt;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     dif_w;
    logic [WIDTH-1:0]   s_res;
    logic [WIDTH-1:0]   s_rem;
    logic               s_carry;
    logic               s_dbz;
    logic               iter_req;

    logic               fin;
    logic [WIDTH-1:0]   f_res;
    logic [WIDTH-1:0]   f_rem;
    logic               f_carry;
    logic               f_dbz;

    assign ac_load = done;

    // One MUL step and one DIV step, computed combinationally.
    // The last step is written straight to the outputs.
    // Because of that, the final partial values are never stored first.
    always_comb begin
        acc_nxt = mb[0] ? (acc + mc) : acc;
        // Restoring divide step.
        // The trial subtraction cannot wrap: the partial remainder is always below the divisor.
        // So bit WIDTH of trial is set exactly when the divisor does not fit.
        trial = {prem, quo[WIDTH-1]} - {1'b0, dvs};
        if (trial[WIDTH]) begin
            prem_nxt = {prem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nxt  = {quo[WIDTH-2:0], 1'b0};
        end else begin
            prem_nxt = trial[WIDTH-1:0];
            quo_nxt  = {quo[WIDTH-2:0], 1'b1};
        end
    end

    // Single-cycle results.
    // DIV only reaches its case item here when b is zero.
    always_comb begin
        sum_w    = {1'b0, a} + {1'b0, b};
        dif_w    = {1'b0, a} - {1'b0, b};
        s_res    = a;
        s_rem    = '0;
        s_carry  = 1'b0;
        s_dbz    = 1'b0;
        iter_req = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
        case (op)
            OP_ADD: begin
                s_res   = sum_w[WIDTH-1:0];
                s_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                s_res   = dif_w[WIDTH-1:0];
                s_carry = dif_w[WIDTH];
            end
            OP_AND:   s_res = a & b;
            OP_OR:    s_res = a | b;
            OP_XOR:   s_res = a ^ b;
            OP_NOT:   s_res = ~a;
            OP_SHL: begin
                s_res   = {a[WIDTH-2:0], 1'b0};
                s_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                s_res   = {1'b0, a[WIDTH-1:1]};
                s_carry = a[0];
            end
            OP_PASSB: s_res = b;
            OP_DIV: begin
                s_res = '1;
                s_rem = a;
                s_dbz = 1'b1;
            end
            default:  s_res = a;
        endcase
    end

    // Select which completion, if any, updates the outputs on this edge.
    always_comb begin
        fin     = 1'b0;
        f_res   = s_res;
        f_rem   = s_rem;
        f_carry = s_carry;
        f_dbz   = s_dbz;
        if (state == IDLE) begin
            fin = start && !iter_req;
        end else if (cnt == LAST_ITER) begin
            fin   = 1'b1;
            f_dbz = 1'b0;
            if (is_div) begin
                f_res   = quo_nxt;
                f_rem   = prem_nxt;
                f_carry = 1'b0;
            end else begin
                f_res   = acc_nxt[WIDTH-1:0];
                f_rem   = '0;
                f_carry = |acc_nxt[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rem    <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                result <= f_res;
                rem    <= f_rem;
                carry  <= f_carry;
                dbz    <= f_dbz;
                zero   <= (f_res == '0);
                neg    <= f_res[WIDTH-1];
            end
            case (state)
                IDLE: begin
                    if (start && iter_req) begin
                        state  <= EXEC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= (op == OP_DIV);
                    end
                end
                EXEC: begin
                    if (cnt == LAST_ITER) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Iteration datapath.
    // Loaded on every accepted start and stepped once per EXEC cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (start) begin
                mc   <= {{WIDTH{1'b0}}, a};
                mb   <= b;
                acc  <= '0;
                quo  <= a;
                prem <= '0;
                dvs  <= b;
            end
        end else begin
            acc  <= acc_nxt;
            mc   <= mc << 1;
            mb   <= mb >> 1;
            quo  <= quo_nxt;
            prem <= prem_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard testbench for alu_seq.
//
// The stimulus process issues directed and random ops.
// For each accepted op it pushes the expected outputs and the expected done cycle into a queue.
// The monitor process pops that queue on every done pulse and compares.
// Between pulses, the monitor checks that all outputs hold their last values.
module tb_alu_seq;
    localparam int W = 10;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic [W-1:0] rem;
    logic         done;
    logic         ac_load;
    logic         busy;
    logic         zero;
    logic         carry;
    logic         neg;
    logic         dbz;

    alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .rem(rem), .done(done), .ac_load(ac_load),
        .busy(busy), .zero(zero), .carry(carry), .neg(neg), .dbz(dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         carry;
        logic         zero;
        logic         neg;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t held;

    function automatic exp_t zero_exp();
        exp_t e;
        e.res = '0; e.rem = '0; e.carry = 1'b0; e.zero = 1'b0;
        e.neg = 1'b0; e.dbz = 1'b0; e.cyc = 0;
        return e;
    endfunction

    // Reference model: the opcode table written as plain unsigned integer arithmetic.
    function automatic exp_t model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y);
        exp_t e;
        int unsigned xi, yi, p;
        xi = x; yi = y;
        e = zero_exp();
        e.res = x;
        case (o)
            4'd0: begin p = xi + yi; e.res = W'(p % M); e.carry = (p >= M); end
            4'd1: begin e.res = W'((xi + M - yi) % M); e.carry = (xi < yi); end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = ~x;
            4'd6: begin e.res = W'((xi * 2) % M); e.carry = (xi >= M / 2); end
            4'd7: begin e.res = W'(xi / 2); e.carry = (xi % 2 == 1); end
            4'd8: e.res = y;
            4'd9: begin p = xi * yi; e.res = W'(p % M); e.carry = (p >= M); end
            4'd10: begin
                if (yi == 0) begin
                    e.res = W'(M - 1); e.rem = x; e.dbz = 1'b1;
                end else begin
                    e.res = W'(xi / yi); e.rem = W'(xi % yi);
                end
            end
            default: e.res = x;
        endcase
        e.zero = (e.res == 0);
        e.neg  = (e.res >= M / 2);
        return e;
    endfunction

    function automatic logic [31:0] pk(exp_t e);
        return {8'b0, e.res, e.rem, e.carry, e.zero, e.neg, e.dbz};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            logic [31:0] act;
            act = {8'b0, result, rem, carry, zero, neg, dbz};
            chk("ac_load_eq_done", {31'b0, ac_load}, {31'b0, done});
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL missing_done: got none required done at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
                    held.res = result; held.rem = rem; held.carry = carry;
                    held.zero = zero; held.neg = neg; held.dbz = dbz;
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("outputs", act, pk(e));
                    held = e;
                end
            end else begin
                chk("hold", act, pk(held));
            end
        end
    end

    // Issue one op at a negedge with busy low.
    // The task returns at the negedge where its done pulse is visible.
    task automatic issue(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, bit inject);
        exp_t e;
        int lat;
        e = model(o, x, y);
        lat = ((o == 4'd9) || (o == 4'd10 && y != 0)) ? W : 0;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (lat != 0) begin
            chk("busy_iter", {31'b0, busy}, 32'd1);
            for (int k = 1; k < W; k++) begin
                if (inject && k == 3) begin
                    // Start during busy: must be ignored, operands must not be re-sampled.
                    start = 1'b1; op = 4'd0; a = W'($urandom); b = W'($urandom);
                end
                @(negedge clk);
                start = 1'b0;
                chk("busy_iter", {31'b0, busy}, 32'd1);
            end
            @(negedge clk);
        end
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        held = zero_exp();
        repeat (3) @(negedge clk);
        chk("reset_state", {18'b0, done, ac_load, busy, zero, carry, neg, dbz, result != 0, rem != 0},
            32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD / SUB
        issue(4'd0, 10'd1000, 10'd30, 1'b0);
        chk("add_res", {22'b0, result}, 32'd6);
        chk("add_carry", {31'b0, carry}, 32'd1);
        issue(4'd1, 10'd5, 10'd7, 1'b0);
        chk("sub_res", {22'b0, result}, 32'd1022);
        chk("sub_flags", {30'b0, carry, neg}, 32'd3);

        // MUL
        issue(4'd9, 10'd25, 10'd40, 1'b0);
        chk("mul_res", {22'b0, result}, 32'd1000);
        chk("mul_carry", {31'b0, carry}, 32'd0);
        issue(4'd9, 10'd40, 10'd40, 1'b0);
        chk("mul_ovf_res", {22'b0, result}, 32'd576);
        chk("mul_ovf_carry", {31'b0, carry}, 32'd1);

        // DIV (ADD pulsed during the DIV must be ignored)
        issue(4'd10, 10'd1000, 10'd7, 1'b1);
        chk("div_res", {22'b0, result}, 32'd142);
        chk("div_rem", {22'b0, rem}, 32'd6);
        issue(4'd10, 10'd9, 10'd0, 1'b0);
        chk("dbz_res", {22'b0, result}, 32'd1023);
        chk("dbz_rem", {22'b0, rem}, 32'd9);
        chk("dbz_flag", {31'b0, dbz}, 32'd1);

        // SHL then SHR back-to-back
        issue(4'd6, 10'd512, 10'd0, 1'b0);
        chk("shl_flags", {22'b0, result}, 32'd0);
        chk("shl_zc", {30'b0, zero, carry}, 32'd3);
        chk("dbz_cleared", {31'b0, dbz}, 32'd0);
        issue(4'd7, 10'd3, 10'd0, 1'b0);
        chk("shr_res", {22'b0, result}, 32'd1);
        chk("shr_carry", {31'b0, carry}, 32'd1);

        // Reset during the 5th MUL iteration
        op = 4'd9; a = 10'd25; b = 10'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_abort", {20'b0, result, done, busy}, 32'd0);
        sb.delete();
        held = zero_exp();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_busy", {31'b0, busy}, 32'd0);
        issue(4'd0, 10'd1, 10'd1, 1'b0);
        chk("add_after_rst", {22'b0, result}, 32'd2);

        // Random back-to-back traffic
        for (int i = 0; i < 300; i++) begin
            logic [3:0]   o;
            logic [W-1:0] x, y;
            o = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(o, x, y, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequenced arithmetic/logic unit that sits directly upstream of the accumulator register.
- Takes two 10-bit operands and an opcode and produces a 10-bit result with status flags.
- Issues a one-cycle load strobe that drives the accumulator's read-enable, so the result is captured on the next edge.
- Simple ops complete in one cycle. MUL (shift-add) and DIV (restoring) are iterative and take WIDTH cycles.

Parameters:
- WIDTH, 10, datapath width; matches the accumulator width.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted on a rising edge when busy=0.
- op  input  4  opcode, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- result  output  WIDTH  registered result.
- rem  output  WIDTH  DIV remainder; 0 for all other ops.
- done  output  1  one-cycle pulse: result, rem and flags are valid.
- ac_load  output  1  identical to done; wired to the accumulator's read-enable.
- busy  output  1  high while MUL/DIV iterations are in progress.
- zero  output  1  result==0.
- carry  output  1  carry/borrow/shift-out/MUL-overflow.
- neg  output  1  result[WIDTH-1].
- dbz  output  1  divide-by-zero flag.

Behaviour:
- Reset (async, active-high) forces:
  - all outputs to 0;
  - FSM to IDLE and iteration counter to 0.
  - Asserting rst mid-MUL/DIV aborts the operation: no done pulse, busy low immediately.
- FSM states: IDLE and EXEC.
- Start rules:
  - start is accepted only when busy=0.
  - start while busy=1 is ignored, and op/a/b are not re-sampled.
  - Back-to-back starts are allowed. start may be high in the same cycle as done.
- Opcodes:
  - 0 ADD: {carry,result}=a+b.
  - 1 SUB: result=a-b; carry=1 on borrow (a<b).
  - 2 AND, 3 OR, 4 XOR: bitwise; carry=0.
  - 5 NOT: result=~a; carry=0.
  - 6 SHL: result=a<<1; carry=a[WIDTH-1].
  - 7 SHR: logical, result=a>>1; carry=a[0].
  - 8 PASSB: result=b.
  - 9 MUL: result=low WIDTH bits of a*b (unsigned); carry=1 if the high WIDTH bits are nonzero.
  - 10 DIV: unsigned; result=a/b; rem=a%b; carry=0.
  - 11-15: pass A (result=a), carry=0.
- Single-cycle ops (0-8, 11-15, and DIV with b==0):
  - start accepted at edge N; FSM stays in IDLE.
  - result, rem, flags and done/ac_load are registered at edge N.
  - done is high for exactly one cycle, then drops at edge N+1 unless a new op completes on that edge.
- MUL/DIV with a valid divisor:
  - At edge N: operands are captured, busy=1, FSM goes to EXEC, counter=0.
  - One iteration is performed per edge, N+1 through N+WIDTH.
  - At edge N+WIDTH, result/rem/flags are written, done=1, busy=0, FSM returns to IDLE.
  - Latency is WIDTH cycles: 10 by default.
- Divide by zero (DIV with b==0):
  - result=all ones; rem=a; dbz=1; carry=0; single-cycle latency.
  - dbz is cleared by the next completed op that is not a divide-by-zero.
- Flags:
  - zero and neg are computed from the final result.
  - All flags, result and rem update only on the completing edge; they hold between ops.
- Intermediate MUL/DIV partial values are never visible on result.

Test Plan:
- Reset mid-op: assert rst during MUL iteration 5 -> done, busy and result all 0 immediately; no done pulse afterwards; a following ADD 1+1 returns result=2.
- ADD/SUB:
  - ADD a=1000, b=30 -> one edge later result=6, carry=1, done=ac_load=1 for exactly one cycle.
  - SUB a=5, b=7 -> result=1022, carry=1, neg=1.
- MUL:
  - a=25, b=40 -> busy high for 10 cycles, then result=1000, carry=0, done pulse at edge N+10.
  - a=40, b=40 -> result=576, carry=1.
- DIV:
  - a=1000, b=7 -> result=142, rem=6, done at edge N+10.
  - a=9, b=0 -> next edge result=1023, rem=9, dbz=1.
- Start while busy: pulse start with ADD during a DIV -> ignored; the DIV result is unaffected; exactly one done pulse occurs.
- Back-to-back and shifts: SHL a=512 -> result=0, zero=1, carry=1. start held high with SHR a=3 on the done cycle -> next edge result=1, carry=1, done high again.
